// File: rtl/dsm_filter_pkg.sv
// Shared constants for the delta-sigma decimation filter chain.
// Holds the halfband coefficient set, the tap count, the output shift, the
// halfband sequencer state encoding, and a modulo-15 tap addressing helper.
package dsm_filter_pkg;

    localparam int HBF_NTAPS = 15;
    localparam int HBF_SHIFT = 15;

    // Q1.15 halfband taps; centre plus odd-distance pairs, sum = 32768.
    localparam logic signed [15:0] HBF_CC = 16'sd16384;
    localparam logic signed [15:0] HBF_C1 = 16'sd10050;
    localparam logic signed [15:0] HBF_C3 = -16'sd2423;
    localparam logic signed [15:0] HBF_C5 = 16'sd725;
    localparam logic signed [15:0] HBF_C7 = -16'sd160;

    typedef enum logic [1:0] {
        HBF_IDLE  = 2'd0,
        HBF_MAC   = 2'd1,
        HBF_ROUND = 2'd2,
        HBF_OUT   = 2'd3
    } hbf_state_t;

    // Buffer index of the sample k positions older than the newest one.
    function automatic logic [3:0] hbf_tap_idx(input logic [3:0] newest,
                                               input logic [3:0] k);
        logic [4:0] s;
        s = {1'b0, newest} + 5'(HBF_NTAPS) - {1'b0, k};
        if (s >= 5'(HBF_NTAPS))
            s = s - 5'(HBF_NTAPS);
        return s[3:0];
    endfunction

endpackage

// File: rtl/hbf_mac.sv
// Serial multiply-accumulate datapath for the halfband decimator.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             zero the accumulator (held while the sequencer idles)
//   en              accumulate (samp_a + samp_b) * coef this cycle
//   samp_a, samp_b  symmetric tap pair, two's complement
//   coef            signed Q1.15 coefficient
//   rnd_data        accumulator rounded to nearest, shifted, saturated
//   rnd_sat         rnd_data is a clamped value
module hbf_mac #(
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 24,
    parameter int ACC_W  = 44,
    parameter int SHIFT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] samp_a,
    input  logic signed [DATA_W-1:0] samp_b,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [OUT_W-1:0]  rnd_data,
    output logic                     rnd_sat
);

    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PRE_W-1:0]  pre;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;

    assign pre  = PRE_W'(samp_a) + PRE_W'(samp_b);
    assign prod = PROD_W'(pre) * PROD_W'(coef);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

    assign shifted = (acc + RND_HALF) >>> SHIFT;

    always_comb begin
        rnd_sat  = 1'b0;
        rnd_data = shifted[OUT_W-1:0];
        if (shifted > OUT_MAX) begin
            rnd_sat  = 1'b1;
            rnd_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < OUT_MIN) begin
            rnd_sat  = 1'b1;
            rnd_data = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/hbf_decim2.sv
// Halfband FIR decimate-by-2 stage following the CIC decimator.
// Converts offset-binary CIC words to two's complement, stores them in a
// 15-entry circular buffer and, on every second accepted sample, runs a
// 5-cycle serial MAC over the symmetric 15-tap halfband, then rounds and
// saturates to a 24-bit output word.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     one-cycle strobe qualifying in_data
//   in_data      CIC output, offset-binary
//   bypass       (HBF_BYPASS_EN builds only) pass trigger samples unfiltered
//   out_valid    one-cycle strobe, out_data updated
//   out_data     filtered sample, two's complement
//   busy         MAC sequence in progress; input samples are dropped
//   overrun      sticky: a sample arrived while busy
//   sat          sticky: an output was clamped
// Build option: define HBF_BYPASS_EN to add the bypass port and path.
//
// state     | meaning
// ----------+------------------------------------------------------------
// HBF_IDLE  | waiting for a trigger (odd-phase) sample
// HBF_MAC   | 5 cycles: pair distances 1,3,5,7 then the centre tap
// HBF_ROUND | round/saturate accumulator, load out_data, raise out_valid
// HBF_OUT   | out_valid visible; in bypass, load the raw trigger sample
module hbf_decim2
    import dsm_filter_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 24,
    parameter int ACC_W  = 44
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef HBF_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    hbf_state_t state, state_nxt;

    logic signed [DATA_W-1:0] buf_mem [HBF_NTAPS];
    logic [3:0]               wptr;
    logic [3:0]               newest;
    logic                     phase;
    logic [2:0]               step;
    logic                     accept;
    logic                     trigger;
    logic signed [DATA_W-1:0] sample_in;

    logic [3:0]               ka, kb;
    logic signed [DATA_W-1:0] samp_a, samp_b;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [OUT_W-1:0]  rnd_data;
    logic                     rnd_sat;
    logic                     load_out;
    logic [OUT_W-1:0]         out_nxt;

    assign sample_in = {~in_data[DATA_W-1], in_data[DATA_W-2:0]};
    assign busy      = (state != HBF_IDLE);
    assign accept    = in_valid && !busy;
    assign trigger   = accept && phase;
    assign newest    = (wptr == 4'd0) ? 4'(HBF_NTAPS - 1) : wptr - 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HBF_NTAPS; i++)
                buf_mem[i] <= '0;
            wptr  <= '0;
            phase <= 1'b0;
        end else if (accept) begin
            buf_mem[wptr] <= sample_in;
            wptr  <= (wptr == 4'(HBF_NTAPS - 1)) ? 4'd0 : wptr + 4'd1;
            phase <= ~phase;
        end
    end

    // k counts back from the newest sample; the centre tap sits at k=7.
    always_comb begin
        ka       = 4'd7;
        kb       = 4'd7;
        coef_sel = COEF_W'(HBF_CC);
        case (step)
            3'd0: begin ka = 4'd6; kb = 4'd8;  coef_sel = COEF_W'(HBF_C1); end
            3'd1: begin ka = 4'd4; kb = 4'd10; coef_sel = COEF_W'(HBF_C3); end
            3'd2: begin ka = 4'd2; kb = 4'd12; coef_sel = COEF_W'(HBF_C5); end
            3'd3: begin ka = 4'd0; kb = 4'd14; coef_sel = COEF_W'(HBF_C7); end
            default: ;
        endcase
    end

    assign samp_a = buf_mem[hbf_tap_idx(newest, ka)];
    assign samp_b = (step >= 3'd4) ? '0 : buf_mem[hbf_tap_idx(newest, kb)];

    hbf_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .ACC_W  (ACC_W),
        .SHIFT  (HBF_SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == HBF_IDLE),
        .en       (state == HBF_MAC),
        .samp_a   (samp_a),
        .samp_b   (samp_b),
        .coef     (coef_sel),
        .rnd_data (rnd_data),
        .rnd_sat  (rnd_sat)
    );

`ifdef HBF_BYPASS_EN
    logic byp_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            byp_r <= 1'b0;
        else if (trigger)
            byp_r <= bypass;
    end

    // Bypass reuses HBF_OUT as its single busy cycle; out_valid lands a
    // cycle later, after the sequencer is already idle again.
    assign load_out = (state == HBF_ROUND) || (state == HBF_OUT && byp_r);
    assign out_nxt  = byp_r ? OUT_W'(buf_mem[newest]) : rnd_data;
`else
    assign load_out = (state == HBF_ROUND);
    assign out_nxt  = rnd_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HBF_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HBF_IDLE: begin
                if (trigger) begin
`ifdef HBF_BYPASS_EN
                    state_nxt = bypass ? HBF_OUT : HBF_MAC;
`else
                    state_nxt = HBF_MAC;
`endif
                end
            end
            HBF_MAC:   if (step == 3'd4) state_nxt = HBF_ROUND;
            HBF_ROUND: state_nxt = HBF_OUT;
            HBF_OUT:   state_nxt = HBF_IDLE;
            default:   state_nxt = HBF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step <= '0;
        else if (state == HBF_MAC)
            step <= step + 3'd1;
        else
            step <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            out_valid <= load_out;
            if (load_out)
                out_data <= out_nxt;
            if (in_valid && busy)
                overrun <= 1'b1;
            if (state == HBF_ROUND && rnd_sat)
                sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hbf_decim2.sv
module tb_hbf_decim2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = 24'h800000;
`ifdef HBF_BYPASS_EN
    logic        bypass = 1'b0;
`endif
    logic        out_valid;
    logic [23:0] out_data;
    logic        busy;
    logic        overrun;
    logic        sat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] outq[$];

    always #5 clk = ~clk;

    hbf_decim2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef HBF_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .overrun   (overrun),
        .sat       (sat)
    );

    always @(negedge clk)
        if (rst_n && out_valid)
            outq.push_back(out_data);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] qget(input int i);
        if (i < outq.size())
            return outq[i];
        return 24'hxxxxxx;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
    endtask

    task automatic send(input logic [23:0] d);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // n samples, one every 64 clocks; sample imp_idx carries imp instead of base
    task automatic run_stream(input int n, input int imp_idx,
                              input logic [23:0] base, input logic [23:0] imp);
        for (int i = 0; i < n; i++) begin
            send((i == imp_idx) ? imp : base);
            repeat (62) @(posedge clk);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    logic [23:0] imp_exp [12];
    int          nz;

    initial begin
        imp_exp = '{24'h000000, 24'h000000, 24'hFFB000, 24'h016A80,
                    24'hFB4480, 24'h13A100, 24'h13A100, 24'hFB4480,
                    24'h016A80, 24'hFFB000, 24'h000000, 24'h000000};

        // reset values
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_busy",      busy,      0);
        check("rst_overrun",   overrun,   0);
        check("rst_sat",       sat,       0);
        @(negedge clk);
        rst_n = 1'b1;

        // DC gain
        run_stream(20, -1, 24'h900000, 24'h0);
        check("dc_count", outq.size(), 10);
        check("dc_first", qget(0), 24'hFFEC00);
        for (int i = 7; i < 10; i++)
            check($sformatf("dc_out%0d", i), qget(i), 24'h100000);
        check("dc_sat",     sat,     0);
        check("dc_overrun", overrun, 0);

        // impulse on a stored-only sample: only the centre tap sees it
        do_reset;
        run_stream(20, 4, 24'h800000, 24'hC00000);
        check("imp0_count", outq.size(), 10);
        nz = 0;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i] != 24'h0) nz++;
        check("imp0_nonzero", nz, 1);
        check("imp0_value", qget(5), 24'h200000);

        // impulse on a trigger sample: all the odd taps
        do_reset;
        run_stream(24, 5, 24'h800000, 24'hC00000);
        check("imp1_count", outq.size(), 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("imp1_out%0d", i), qget(i), imp_exp[i]);

        // round-half-up on the smallest positive centre contribution
        do_reset;
        run_stream(20, 4, 24'h800000, 24'h800001);
        check("rnd_value", qget(5), 24'h000001);

        // overrun and latency
        do_reset;
        send(24'h800000);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 24'hC00000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ovr_busy_c1", busy, 1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 24'hFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovr_valid_c6", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_c7", out_valid, 1);
        check("ovr_data_c7",  out_data,  24'hFFB000);
        check("ovr_busy_c7",  busy,      1);
        check("ovr_flag",     overrun,   1);
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_c8", out_valid, 0);
        check("ovr_busy_c8",  busy,      0);
        outq.delete();
        send(24'h800000);
        send(24'h800000);
        repeat (10) @(posedge clk);
        check("ovr_next_count", outq.size(), 1);
        check("ovr_next_value", qget(0), 24'h016A80);

        // asynchronous reset in the middle of a MAC sequence
        send(24'h800000);
        send(24'hC00000);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_out_data", out_data,  0);
        check("amid_busy",     busy,      0);
        check("amid_overrun",  overrun,   0);
        check("amid_valid",    out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
        send(24'hC00000);
        repeat (30) @(posedge clk);
        check("amid_no_output", outq.size(), 0);
        send(24'hC00000);
        repeat (10) @(posedge clk);
        check("amid_resume_count", outq.size(), 1);
        check("amid_resume_value", qget(0), 24'hFFB000);

        // saturation on a full-scale step
        do_reset;
        run_stream(16, -1, 24'h000000, 24'h0);
        run_stream(16, -1, 24'hFFFFFF, 24'h0);
        check("sat_count", outq.size(), 16);
        check("sat_out11", qget(11), 24'h3FFFFF);
        check("sat_out12", qget(12), 24'h7FFFFF);
        check("sat_out13", qget(13), 24'h7B95FF);
        check("sat_out15", qget(15), 24'h7FFFFF);
        nz = 0;
        for (int i = 11; i < outq.size(); i++)
            if (outq[i][23]) nz++;
        check("sat_no_wrap", nz, 0);
        check("sat_flag", sat, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
